// File: rtl/da_dct_sequencer_if.sv
// Handshake and ROM bus bundle for da_dct_sequencer.
// slave  : the sequencer side (consumes x0..x3 and rom_data, produces results).
// master : the environment side (butterfly stage, ROM and output stage).
interface da_dct_sequencer_if #(
  parameter int W  = 8,
  parameter int DW = 16,
  parameter int AW = DW + W + 1
);
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         x0;
  logic [W-1:0]         x1;
  logic [W-1:0]         x2;
  logic [W-1:0]         x3;
  logic                 rom_cs;
  logic [2:0]           rom_addr;
  logic signed [DW-1:0] rom_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_data;

  modport slave (
    input  in_valid, x0, x1, x2, x3, rom_data, out_ready,
    output in_ready, rom_cs, rom_addr, out_valid, out_data
  );

  modport master (
    output in_valid, x0, x1, x2, x3, rom_data, out_ready,
    input  in_ready, rom_cs, rom_addr, out_valid, out_data
  );
endinterface

// File: rtl/da_dct_sequencer.sv
// Distributed-arithmetic DCT coefficient sequencer.
// Captures four signed W-bit butterfly terms, walks them bit-serially LSB
// first, addresses a shared 8-entry DA ROM with the x0-folded bit slice and
// shift-accumulates the returned words into an exact AW-bit result.
// Optional build macro: DA_CS_GATE_EN -- when defined, rom_cs is asserted only
// during RUN cycles; otherwise rom_cs is high in every state except WAKE.
module da_dct_sequencer #(
  parameter int                   W      = 8,
  parameter int                   DW     = 16,
  parameter int                   AW     = DW + W + 1,
  parameter logic signed [AW-1:0] OFFSET = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  da_dct_sequencer_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    ST_WAKE = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        j_q, j_d;
  logic [W-1:0]         x_q [4];
  logic [W-1:0]         x_d [4];
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;

  // Incoming terms gathered into an array so the bit slice can be generated.
  logic [W-1:0] x_in [4];
  assign x_in[0] = bus.x0;
  assign x_in[1] = bus.x1;
  assign x_in[2] = bus.x2;
  assign x_in[3] = bus.x3;

  // Bit j of each captured term.
  logic [3:0] bit_slice;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign bit_slice[gi] = x_q[gi][j_q];
    end
  endgenerate

  // ROM symmetry: when x0's bit is set, the complementary address holds the
  // negated word, so the ROM only stores half the combinations' worth.
  logic [2:0] slice_addr;
  logic [2:0] run_addr;
  assign slice_addr = {bit_slice[1], bit_slice[2], bit_slice[3]};
  assign run_addr   = bit_slice[0] ? ~slice_addr : slice_addr;

  // Sign-extended ROM word, folded and weighted by 2^j. Width AW keeps the
  // largest magnitude (2^(DW-1) << (W-1)) exact.
  logic signed [AW-1:0] rom_ext;
  logic signed [AW-1:0] term;
  logic signed [AW-1:0] shifted;
  logic signed [AW-1:0] acc_add;
  logic signed [AW-1:0] acc_sub;
  logic                 last_bit;

  assign rom_ext  = {{(AW-DW){bus.rom_data[DW-1]}}, bus.rom_data};
  assign term     = bit_slice[0] ? -rom_ext : rom_ext;
  assign shifted  = term << j_q;
  assign acc_add  = acc_q + shifted;
  // The MSB of a two's complement input carries weight -2^(W-1).
  assign acc_sub  = acc_q - shifted;
  assign last_bit = (j_q == CW'(W - 1));

  // Outputs are decoded from registered state; address is live only in RUN.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.rom_addr  = (state_q == ST_RUN) ? run_addr : 3'b000;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
`ifdef DA_CS_GATE_EN
  assign bus.rom_cs    = (state_q == ST_RUN);
`else
  assign bus.rom_cs    = (state_q != ST_WAKE);
`endif

  // Next-state and datapath update for the WAKE/IDLE/RUN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    for (int i = 0; i < 4; i++) begin
      x_d[i] = x_q[i];
    end

    case (state_q)
      ST_WAKE: begin
        // ROM is still in its synchronised reset cycle; just wait it out.
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.in_valid) begin
          for (int i = 0; i < 4; i++) begin
            x_d[i] = x_in[i];
          end
          acc_d   = '0;
          j_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_bit) begin
          acc_d       = acc_sub;
          out_data_d  = acc_sub + OFFSET;
          out_valid_d = 1'b1;
          j_d         = '0;
          state_d     = ST_DONE;
        end else begin
          acc_d = acc_add;
          j_d   = j_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_WAKE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAKE;
      j_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= x_d[i];
      end
    end
  end

endmodule

// File: tb/tb_da_dct_sequencer.sv
// Bench for da_dct_sequencer: directed test-plan vectors, random vectors
// against an arithmetic DA model, backpressure and mid-run reset.
// A second instance with OFFSET=100 runs in lockstep on the same stimulus.
module tb_da_dct_sequencer;
  localparam int W  = 8;
  localparam int DW = 16;
  localparam int AW = DW + W + 1;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  logic signed [DW-1:0] rom_tbl [8];

`ifdef DA_CS_GATE_EN
  localparam logic CS_IDLE = 1'b0;
`else
  localparam logic CS_IDLE = 1'b1;
`endif

  da_dct_sequencer_if #(.W(W), .DW(DW), .AW(AW)) bus ();
  da_dct_sequencer_if #(.W(W), .DW(DW), .AW(AW)) bus_off ();

  da_dct_sequencer #(.W(W), .DW(DW), .AW(AW), .OFFSET('0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  da_dct_sequencer #(.W(W), .DW(DW), .AW(AW), .OFFSET(25'sd100)) u_dut_off (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_off.slave)
  );

  // ROM model: combinational read, returns 0 while deselected.
  assign bus.rom_data     = bus.rom_cs ? rom_tbl[bus.rom_addr] : '0;
  assign bus_off.rom_data = bus_off.rom_cs ? rom_tbl[bus_off.rom_addr] : '0;

  assign bus_off.in_valid  = bus.in_valid;
  assign bus_off.x0        = bus.x0;
  assign bus_off.x1        = bus.x1;
  assign bus_off.x2        = bus.x2;
  assign bus_off.x3        = bus.x3;
  assign bus_off.out_ready = bus.out_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Expected DA result: sum over bits of weight(j) * signed lookup of the slice.
  function automatic logic signed [AW-1:0] model(input logic [W-1:0] a0, a1, a2, a3);
    longint acc;
    longint t;
    longint wgt;
    logic [2:0] adr;
    acc = 0;
    for (int j = 0; j < W; j++) begin
      adr = {a1[j], a2[j], a3[j]};
      if (a0[j]) adr = ~adr;
      t = longint'(rom_tbl[adr]);
      if (a0[j]) t = -t;
      wgt = (j == W - 1) ? -(longint'(1) << j) : (longint'(1) << j);
      acc = acc + t * wgt;
    end
    return acc[AW-1:0];
  endfunction

  function automatic logic [2:0] exp_addr(input logic [W-1:0] a0, a1, a2, a3, input int j);
    logic [2:0] adr;
    adr = {a1[j], a2[j], a3[j]};
    return a0[j] ? ~adr : adr;
  endfunction

  // One complete transform: handshake, per-bit address checks, result at W+1.
  task automatic run_xform(input string name, input logic [W-1:0] a0, a1, a2, a3,
                           input logic signed [AW-1:0] expv);
    int n;
    logic signed [AW-1:0] exp_off;
    exp_off = expv + 25'sd100;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n == 20) begin
      failures++;
      $display("FAIL %s in_ready_wait got=%b exp=1", name, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.x0 = a0; bus.x1 = a1; bus.x2 = a2; bus.x3 = a3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x0 = W'($urandom); bus.x1 = W'($urandom);
    bus.x2 = W'($urandom); bus.x3 = W'($urandom);
    for (int j = 0; j < W; j++) begin
      checks++;
      if (bus.rom_addr !== exp_addr(a0, a1, a2, a3, j)) begin
        failures++;
        $display("FAIL %s rom_addr j=%0d got=%b exp=%b", name, j, bus.rom_addr,
                 exp_addr(a0, a1, a2, a3, j));
      end
      checks++;
      if (bus.rom_cs !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s run_ctl j=%0d got cs=%b rdy=%b ov=%b exp cs=1 rdy=0 ov=0",
                 name, j, bus.rom_cs, bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s out_valid_latency got=%b exp=1", name, bus.out_valid);
    end
    checks++;
    if (bus.out_data !== expv) begin
      failures++;
      $display("FAIL %s out_data got=%0d exp=%0d", name, bus.out_data, expv);
    end
    checks++;
    if (bus_off.out_data !== exp_off) begin
      failures++;
      $display("FAIL %s out_data_offset got=%0d exp=%0d", name, bus_off.out_data, exp_off);
    end
    $display("xform %s x=%02h,%02h,%02h,%02h out=%0d exp=%0d out_off=%0d", name,
             a0, a1, a2, a3, bus.out_data, expv, bus_off.out_data);
    if (bus.out_ready === 1'b1) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== expv
          || bus.rom_addr !== 3'b000 || bus.rom_cs !== CS_IDLE) begin
        failures++;
        $display("FAIL %s post_handshake got ov=%b rdy=%b data=%0d addr=%b cs=%b exp ov=0 rdy=1 data=%0d addr=000 cs=%b",
                 name, bus.out_valid, bus.in_ready, bus.out_data, bus.rom_addr, bus.rom_cs,
                 expv, CS_IDLE);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.x0 = '0; bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0
        || bus.rom_addr !== 3'b000 || bus.rom_cs !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got rdy=%b ov=%b data=%0d addr=%b cs=%b exp all zero",
               bus.in_ready, bus.out_valid, bus.out_data, bus.rom_addr, bus.rom_cs);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.rom_cs !== 1'b0) begin
      failures++;
      $display("FAIL wake_cycle got rdy=%b cs=%b exp rdy=0 cs=0", bus.in_ready, bus.rom_cs);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.rom_cs !== CS_IDLE) begin
      failures++;
      $display("FAIL idle_after_wake got rdy=%b cs=%b exp rdy=1 cs=%b",
               bus.in_ready, bus.rom_cs, CS_IDLE);
    end
    $display("reset: in_ready=%b rom_cs=%b", bus.in_ready, bus.rom_cs);
  endtask

  task automatic test_directed();
    run_xform("zero", 8'h00, 8'h00, 8'h00, 8'h00, 25'sd4927);
    run_xform("fold", 8'hFF, 8'h00, 8'h00, 8'h00, -25'sd4177);
    run_xform("x1_lsb", 8'h00, 8'h01, 8'h00, 8'h00, -25'sd11142);
  endtask

  task automatic test_random();
    logic [W-1:0] a0, a1, a2, a3;
    for (int k = 0; k < 12; k++) begin
      a0 = W'($urandom_range(0, 255));
      a1 = W'($urandom_range(0, 255));
      a2 = W'($urandom_range(0, 255));
      a3 = W'($urandom_range(0, 255));
      if (k == 0) begin a0 = 8'h80; a1 = 8'h80; a2 = 8'h80; a3 = 8'h80; end
      if (k == 1) begin a0 = 8'h7F; a1 = 8'h80; a2 = 8'h7F; a3 = 8'h80; end
      run_xform("random", a0, a1, a2, a3, model(a0, a1, a2, a3));
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a0, a1, a2, a3;
    logic signed [AW-1:0] expv;
    a0 = W'($urandom); a1 = W'($urandom); a2 = W'($urandom); a3 = W'($urandom);
    expv = model(a0, a1, a2, a3);
    bus.out_ready = 1'b0;
    run_xform("backpressure", a0, a1, a2, a3, expv);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (c == 2);
      bus.x0 = 8'h55; bus.x1 = 8'hAA;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== expv || bus.in_ready !== 1'b0
          || bus.rom_addr !== 3'b000) begin
        failures++;
        $display("FAIL bp_hold c=%0d got ov=%b data=%0d rdy=%b addr=%b exp ov=1 data=%0d rdy=0 addr=000",
                 c, bus.out_valid, bus.out_data, bus.in_ready, bus.rom_addr, expv);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== expv) begin
      failures++;
      $display("FAIL bp_release got ov=%b rdy=%b data=%0d exp ov=0 rdy=1 data=%0d",
               bus.out_valid, bus.in_ready, bus.out_data, expv);
    end
    $display("backpressure: released, in_ready=%b out_data=%0d", bus.in_ready, bus.out_data);
  endtask

  task automatic test_reset_mid_run();
    bus.in_valid = 1'b1;
    bus.x0 = 8'h3C; bus.x1 = 8'h5A; bus.x2 = 8'h0F; bus.x3 = 8'hF0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b0
        || bus.rom_addr !== 3'b000 || bus.rom_cs !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset got ov=%b data=%0d rdy=%b addr=%b cs=%b exp all zero",
               bus.out_valid, bus.out_data, bus.in_ready, bus.rom_addr, bus.rom_cs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrun_wake got rdy=%b exp=0", bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrun_idle got rdy=%b exp=1", bus.in_ready);
    end
    $display("reset_mid_run: recovered in_ready=%b", bus.in_ready);
    run_xform("after_reset", 8'h00, 8'h00, 8'h00, 8'h00, 25'sd4927);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rom_tbl[0] = -16'sd4927;
    rom_tbl[1] = 16'sd1234;
    rom_tbl[2] = -16'sd7777;
    rom_tbl[3] = 16'sd3000;
    rom_tbl[4] = -16'sd20996;
    rom_tbl[5] = 16'sd15000;
    rom_tbl[6] = -16'sd32768;
    rom_tbl[7] = -16'sd4177;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    run_xform("back_to_back", 8'h12, 8'h34, 8'h56, 8'h78, model(8'h12, 8'h34, 8'h56, 8'h78));
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
